// File: rtl/srl_32_pkg.sv
// Shared ALU datapath constants and types.
// Holds widths, shamt field position and word/shamt typedefs.
package alu_pkg;
    localparam int WIDTH     = 32;
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = 5;

    typedef logic [SHAMT_W-1:0] shamt_t;
    typedef logic [WIDTH-1:0]   word_t;
endpackage

// File: rtl/srl_32_if.sv
// Operand/result bundle for the registered right shifter.
// Signals: A, B, in_valid (to DUT); res, out_valid, zero (from DUT).
interface srl_32_if;
    import alu_pkg::*;

    word_t A;
    word_t B;
    logic  in_valid;
    word_t res;
    logic  out_valid;
    logic  zero;

    modport master (
        output A, B, in_valid,
        input  res, out_valid, zero
    );

    modport slave (
        input  A, B, in_valid,
        output res, out_valid, zero
    );
endinterface

// File: rtl/srl_32_core.sv
// Combinational 5-stage logarithmic barrel shifter, zero-fill right.
// Ports: a_i word in, shamt_i shift amount, res_o shifted word.
module srl_32_core
    import alu_pkg::*;
(
    input  word_t  a_i,
    input  shamt_t shamt_i,
    output word_t  res_o
);
    word_t stg [SHAMT_W+1];

    assign stg[0] = a_i;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 2 ** k;
        assign stg[k+1] = shamt_i[k] ? (stg[k] >> SH) : stg[k];
    end

    assign res_o = stg[SHAMT_W];
endmodule

// File: rtl/srl_32.sv
// Registered 32-bit logical right shift, shamt taken from B[10:6].
// Ports: clk, rst (async high), bus (A, B, in_valid -> res, out_valid, zero).
module srl_32
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    srl_32_if.slave  bus
);
    shamt_t shamt;
    word_t  shifted;

    word_t  res_q, res_d;
    logic   zero_q, zero_d;
    logic   valid_q, valid_d;

    // Only the shamt field of B is consumed; the rest is dropped here.
    logic   unused_b;
    assign unused_b = ^{bus.B[WIDTH-1:SHAMT_LSB+SHAMT_W],
                        bus.B[SHAMT_LSB-1:0]};

    assign shamt = bus.B[SHAMT_LSB +: SHAMT_W];

    srl_32_core u_core (
        .a_i     (bus.A),
        .shamt_i (shamt),
        .res_o   (shifted)
    );

    always_comb begin
        res_d   = res_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            res_d   = shifted;
            zero_d  = (shifted == '0);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign bus.res       = res_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_srl_32.sv
// Self-checking bench for srl_32 against an arithmetic reference model.
// Directed sweep, ignored-bit, hold and reset cases plus random traffic.
module tb_srl_32;
    logic clk;
    logic rst;

    srl_32_if bus ();

    srl_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_res;
    logic        m_zero;
    logic        m_valid;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".res"}, bus.res, m_res);
        chk({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, m_zero});
        chk({tag, ".vld"}, {31'b0, bus.out_valid}, {31'b0, m_valid});
    endtask

    task automatic model_reset();
        m_res   = 32'h0;
        m_zero  = 1'b1;
        m_valid = 1'b0;
    endtask

    // Apply one cycle of input, advance the model, check just after the edge.
    task automatic step(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        v,
                        input string       tag);
        int sh;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = v;
        @(posedge clk);
        #1;
        if (v) begin
            sh      = int'((b / 32'd64) % 32'd32);
            m_res   = a >> sh;
            m_zero  = (m_res == 32'h0);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        check_all(tag);
    endtask

    // Async reset pulse placed mid-cycle, away from any clock edge.
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.A        = 32'h0;
        bus.B        = 32'h0;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        step(32'hDEADBEEF, 32'h0000_0080, 1'b1, "pre");
        rst_pulse("rst_async");

        for (int k = 1; k < 32; k++) begin
            step(32'h7FFF_FFFF, 32'h40 * k, 1'b1, "sweep");
            if (k == 1)  chk("sweep1",  bus.res, 32'h3FFF_FFFF);
            if (k == 16) chk("sweep16", bus.res, 32'h0000_7FFF);
            if (k == 30) chk("sweep30", bus.res, 32'h0000_0001);
            if (k == 31) chk("sweep31", {31'b0, bus.zero}, 32'h1);
        end

        step(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, "sh0");
        chk("sh0_k", bus.res, 32'h7FFF_FFFF);
        step(32'h1234_5678, 32'hFFFF_F83F, 1'b1, "ign");
        chk("ign_k", bus.res, 32'h1234_5678);
        step(32'h1234_5678, 32'h0000_0100, 1'b1, "sh4");
        chk("sh4_k", bus.res, 32'h0123_4567);
        step(32'h8000_0000, 32'h0000_07C0, 1'b1, "nosx31");
        chk("nosx31_k", bus.res, 32'h0000_0001);
        step(32'hF000_0000, 32'h0000_0100, 1'b1, "nosx4");
        chk("nosx4_k", bus.res, 32'h0F00_0000);

        for (int i = 0; i < 3; i++)
            step($urandom, $urandom, 1'b0, "hold");
        chk("hold_k", bus.res, 32'h0F00_0000);

        step(32'hCAFE_F00D, 32'h0000_0040, 1'b1, "pend");
        rst_pulse("rst_mid");
        for (int i = 0; i < 3; i++)
            step($urandom, $urandom, 1'b0, "stale");

        // Reset held across a valid edge: nothing may be captured.
        @(negedge clk);
        bus.A        = 32'hFFFF_FFFF;
        bus.B        = 32'h0;
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_all("rst_edge");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;

        step(32'h0000_0000, 32'h0000_0000, 1'b1, "zero_in");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h0;
            step(a, b, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
